cnt_datapath: RTL and testbench
===============================

CNT_DATAPATH -- requirements
Module: cnt_datapath

Interface
REQ-001 Parameter DIV, default 50000000, tick prescaler period in CLK cycles (legal ≥2).
REQ-002 Parameter DEB_CYCLES, default 16, debounce stability window in CLK cycles (legal ≥1).
REQ-003 Parameter MAX_INIT, default 6'd59, Max_Val value after reset.
REQ-004 CLK  in  1  system clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 BTN_RAW  in  1  raw pause/reset push-button, asynchronous, bouncy.
REQ-007 SW_MAX  in  6  new maximum value from switches.
REQ-008 LD_MAX  in  1  synchronous load strobe for SW_MAX; acts in every cycle it is high.
REQ-009 CntEn  in  1  count enable from the run/pause control FSM.
REQ-010 PR  out  1  one-cycle pause/reset pulse to the control FSM.
REQ-011 CNT  out  6  current count value.
REQ-012 Max_Val  out  6  registered maximum value.
REQ-013 TICK  out  1  one-cycle prescaler tick.

Function
REQ-014 BTN_RAW SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: stable level SHALL update only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles; any cycle of agreement clears the window counter.
REQ-016 PR SHALL be high for exactly one cycle, the cycle after the stable level goes 0->1; no pulse on 1->0; holding the button yields one pulse only.
REQ-017 Prescaler SHALL count 0..DIV-1 free-running, independent of CntEn; TICK SHALL be high for the single cycle where prescaler == DIV-1, then wrap to 0.
REQ-018 CNT SHALL increment by 1 in a cycle where TICK=1, CntEn=1 and CNT < Max_Val; otherwise hold.
REQ-019 CNT SHALL never exceed Max_Val through counting; at CNT == Max_Val it holds regardless of CntEn.
REQ-020 LD_MAX=1 SHALL load Max_Val <= SW_MAX and clear CNT <= 0 in the same edge.
REQ-021 LD_MAX SHALL take priority over a simultaneous increment; the result is CNT=0.
REQ-022 SW_MAX = 0 loaded: CNT SHALL remain 0 until a nonzero Max_Val is loaded.
REQ-023 Loading a value below the current CNT is legal; the clear of REQ-020 applies.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 RST=1 SHALL immediately force PR=0, TICK=0, CNT=0, Max_Val=MAX_INIT, prescaler=0, synchronizer and stable level=0, and debounce counter=0.
REQ-026 RST asserted mid-count or mid-debounce SHALL abandon the operation; no PR pulse is generated by the release of RST.
REQ-027 After RST deasserts, the first TICK SHALL occur DIV cycles later.

Configuration
REQ-028 Macro CNT_DEBOUNCE_EN: when defined, the debounce filter of REQ-015 is present.
REQ-029 Without CNT_DEBOUNCE_EN, the synchronized input feeds the edge detector directly (stable level = synchronizer output); PR still fires once per 0->1 edge.

Verification (bench DIV=4, DEB_CYCLES=4, MAX_INIT=59, CNT_DEBOUNCE_EN defined unless noted)
REQ-030 RST pulse mid-run with CNT=17 -> CNT=0, Max_Val=59, PR=0, TICK=0 immediately; first TICK 4 cycles after release.
REQ-031 CntEn=1, SW_MAX=5, LD_MAX one cycle -> CNT steps 0,1,..,5 on successive TICKs (every 4 cycles), then holds at 5 with CntEn still 1.
REQ-032 CntEn=0 for 3 TICKs at CNT=2 -> CNT stays 2; CntEn back to 1 -> next TICK gives 3.
REQ-033 BTN_RAW bounces 1,0,1,0 (1-cycle each), then steady 1 for 20 cycles -> exactly one PR pulse; no pulse on release; bounce shorter than 4 cycles -> no PR.
REQ-034 LD_MAX in the same cycle as TICK with CntEn=1, CNT=3, SW_MAX=10 -> CNT=0, Max_Val=10.
REQ-035 CNT_DEBOUNCE_EN undefined, BTN_RAW clean 0->1 -> PR pulses 3 cycles after the edge (2 sync + 1 edge reg).

Source files
------------

// File: rtl/cnt_datapath_if.sv
// Bus bundle for the counter datapath: button, max-value load, enable and all registered outputs.
// The datapath takes the slave view; whoever drives the inputs takes the master view.
interface cnt_datapath_if;
    logic       BTN_RAW;
    logic [5:0] SW_MAX;
    logic       LD_MAX;
    logic       CntEn;
    logic       PR;
    logic [5:0] CNT;
    logic [5:0] Max_Val;
    logic       TICK;

    modport master (
        output BTN_RAW, SW_MAX, LD_MAX, CntEn,
        input  PR, CNT, Max_Val, TICK
    );

    modport slave (
        input  BTN_RAW, SW_MAX, LD_MAX, CntEn,
        output PR, CNT, Max_Val, TICK
    );
endinterface

// File: rtl/cnt_datapath.sv
// Counter datapath: button synchronizer/debounce/edge pulse, tick prescaler and a bounded up-counter.
// Define CNT_DEBOUNCE_EN to include the debounce filter; otherwise the synchronizer output is used directly.
module cnt_datapath #(
    parameter int         DIV        = 50000000,
    parameter int         DEB_CYCLES = 16,
    parameter logic [5:0] MAX_INIT   = 6'd59
) (
    input  logic          CLK,
    input  logic          RST,
    cnt_datapath_if.slave bus
);

    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_stable;
    logic             r_stablePrev;
    logic             r_pr;
    logic [PRE_W-1:0] r_presc;
    logic             r_tick;
    logic [5:0]       r_cnt;
    logic [5:0]       r_maxVal;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.BTN_RAW;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CNT_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic             r_stable;
    logic [DEB_W-1:0] r_debCnt;

    // The stable level flips only once the synchronized input has disagreed for a full window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stable <= 1'b0;
            r_debCnt <= '0;
        end else if (r_sync2 == r_stable) begin
            r_debCnt <= '0;
        end else if (r_debCnt == DEB_W'(DEB_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_debCnt <= '0;
        end else begin
            r_debCnt <= r_debCnt + 1'b1;
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_sync2;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stablePrev <= 1'b0;
            r_pr         <= 1'b0;
        end else begin
            r_stablePrev <= w_stable;
            r_pr         <= w_stable & ~r_stablePrev;
        end
    end

    // TICK is registered one count early so it lines up with the cycle where the prescaler sits at DIV-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (r_presc == PRE_W'(DIV - 1)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_tick <= (r_presc == PRE_W'(DIV - 2));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= 6'd0;
            r_maxVal <= MAX_INIT;
        end else if (bus.LD_MAX) begin
            r_maxVal <= bus.SW_MAX;
            r_cnt    <= 6'd0;
        end else if (r_tick && bus.CntEn && (r_cnt < r_maxVal)) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign bus.PR      = r_pr;
    assign bus.TICK    = r_tick;
    assign bus.CNT     = r_cnt;
    assign bus.Max_Val = r_maxVal;

endmodule

// File: tb/tb_cnt_datapath.sv
// Directed bench for cnt_datapath with DIV=4, DEB_CYCLES=4, MAX_INIT=59.
// Button latency and bounce expectations follow whether CNT_DEBOUNCE_EN is defined.
module tb_cnt_datapath;

    logic CLK;
    logic RST;
    int   errorCount;
    int   checkCount;

    cnt_datapath_if bus ();

    cnt_datapath #(
        .DIV        (4),
        .DEB_CYCLES (4),
        .MAX_INIT   (6'd59)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef CNT_DEBOUNCE_EN
    localparam int PressLatency = 7;
`else
    localparam int PressLatency = 3;
`endif

    // Single point of comparison: counts every check and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Advances to the negedge where TICK is visible; a missing tick counts as a failure.
    task automatic waitTick(output int steps);
        steps = 0;
        while (bus.TICK !== 1'b1 && steps < 16) begin
            @(negedge CLK);
            steps++;
        end
        if (bus.TICK !== 1'b1) checkOutput("tickTimeout", 32'd0, 32'd1);
    endtask

    task automatic tickAndStep(input int n);
        int s;
        repeat (n) begin
            waitTick(s);
            step(1);
        end
    endtask

    task automatic loadMax(input logic [5:0] value);
        bus.SW_MAX = value;
        bus.LD_MAX = 1'b1;
        step(1);
        bus.LD_MAX = 1'b0;
    endtask

    // Called at the negedge where RST is released: the first TICK lands in the 4th cycle, then every 4.
    task automatic checkFirstTick();
        for (int i = 1; i <= 7; i++) begin
            step(1);
            checkOutput($sformatf("tickAfterReset%0d", i), 32'(bus.TICK), 32'((i == 3 || i == 7) ? 1 : 0));
        end
    endtask

    task automatic applyStimulus(input logic btn, input int cycles, inout int pulses);
        bus.BTN_RAW = btn;
        repeat (cycles) begin
            @(negedge CLK);
            if (bus.PR === 1'b1) pulses++;
        end
    endtask

    initial begin
        int gap;
        int pulses;
        errorCount  = 0;
        checkCount  = 0;
        RST         = 1'b1;
        bus.BTN_RAW = 1'b0;
        bus.SW_MAX  = 6'd0;
        bus.LD_MAX  = 1'b0;
        bus.CntEn   = 1'b0;

        #12;
        checkOutput("resetCnt",  32'(bus.CNT),     32'd0);
        checkOutput("resetMax",  32'(bus.Max_Val), 32'd59);
        checkOutput("resetPr",   32'(bus.PR),      32'd0);
        checkOutput("resetTick", 32'(bus.TICK),    32'd0);
        @(negedge CLK);
        RST = 1'b0;
        checkFirstTick();

        // Load 5 with counting enabled: one step per tick up to 5, then hold.
        bus.CntEn = 1'b1;
        loadMax(6'd5);
        checkOutput("loadCnt", 32'(bus.CNT), 32'd0);
        checkOutput("loadMax", 32'(bus.Max_Val), 32'd5);
        for (int k = 1; k <= 5; k++) begin
            waitTick(gap);
            if (k > 1) checkOutput($sformatf("tickGap%0d", k), 32'(gap), 32'd3);
            step(1);
            checkOutput($sformatf("count%0d", k), 32'(bus.CNT), 32'(k));
        end
        tickAndStep(2);
        checkOutput("holdAtMax", 32'(bus.CNT), 32'd5);

        // Pause at 2 for three ticks, then resume.
        loadMax(6'd12);
        tickAndStep(2);
        checkOutput("countTo2", 32'(bus.CNT), 32'd2);
        bus.CntEn = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tickAndStep(1);
            checkOutput($sformatf("paused%0d", k), 32'(bus.CNT), 32'd2);
        end
        bus.CntEn = 1'b1;
        tickAndStep(1);
        checkOutput("resume", 32'(bus.CNT), 32'd3);

        // Load coinciding with a tick wins over the increment.
        waitTick(gap);
        checkOutput("tickBeforeLoad", 32'(bus.CNT), 32'd3);
        loadMax(6'd10);
        checkOutput("loadOnTickCnt", 32'(bus.CNT), 32'd0);
        checkOutput("loadOnTickMax", 32'(bus.Max_Val), 32'd10);

        // A zero maximum pins the count at 0.
        loadMax(6'd0);
        tickAndStep(2);
        checkOutput("zeroMax", 32'(bus.CNT), 32'd0);

        // Loading below the current count clears it and the new bound holds.
        loadMax(6'd20);
        tickAndStep(4);
        checkOutput("countTo4", 32'(bus.CNT), 32'd4);
        loadMax(6'd2);
        checkOutput("lowLoadCnt", 32'(bus.CNT), 32'd0);
        tickAndStep(3);
        checkOutput("lowLoadHold", 32'(bus.CNT), 32'd2);

        // Asynchronous reset in the middle of a count.
        loadMax(6'd20);
        tickAndStep(17);
        checkOutput("countTo17", 32'(bus.CNT), 32'd17);
        #2 RST = 1'b1;
        #1;
        checkOutput("midResetCnt",  32'(bus.CNT),     32'd0);
        checkOutput("midResetMax",  32'(bus.Max_Val), 32'd59);
        checkOutput("midResetPr",   32'(bus.PR),      32'd0);
        checkOutput("midResetTick", 32'(bus.TICK),    32'd0);
        @(negedge CLK);
        RST = 1'b0;
        checkFirstTick();
        pulses = 0;
        applyStimulus(1'b0, 10, pulses);
        checkOutput("noPrAfterReset", 32'(pulses), 32'd0);

        // Clean press: single pulse at the expected latency, none while held or on release.
        bus.BTN_RAW = 1'b1;
        for (int i = 1; i <= PressLatency + 1; i++) begin
            step(1);
            checkOutput($sformatf("pressPr%0d", i), 32'(bus.PR), 32'((i == PressLatency) ? 1 : 0));
        end
        pulses = 0;
        applyStimulus(1'b1, 15, pulses);
        checkOutput("holdNoPr", 32'(pulses), 32'd0);
        pulses = 0;
        applyStimulus(1'b0, 20, pulses);
        checkOutput("releaseNoPr", 32'(pulses), 32'd0);

`ifdef CNT_DEBOUNCE_EN
        pulses = 0;
        applyStimulus(1'b1, 1, pulses);
        applyStimulus(1'b0, 1, pulses);
        applyStimulus(1'b1, 1, pulses);
        applyStimulus(1'b0, 1, pulses);
        applyStimulus(1'b1, 20, pulses);
        checkOutput("bounceThenHold", 32'(pulses), 32'd1);
        pulses = 0;
        applyStimulus(1'b0, 20, pulses);
        checkOutput("bounceRelease", 32'(pulses), 32'd0);
        pulses = 0;
        applyStimulus(1'b1, 3, pulses);
        applyStimulus(1'b0, 15, pulses);
        checkOutput("shortBounce", 32'(pulses), 32'd0);
`else
        pulses = 0;
        applyStimulus(1'b1, 10, pulses);
        applyStimulus(1'b0, 10, pulses);
        checkOutput("secondPress", 32'(pulses), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
